hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001: The block SHALL use one clock and an asynchronous, active-low reset, with ports named w_clock and w_reset_n.
REQ-002: w_clock  in  1  rising-edge clock for all state.
REQ-003: w_reset_n  in  1  asynchronous active-low reset.
REQ-004: w_id_valid  in  1  decode-stage instruction is valid (decoder w_nop = 0).
REQ-005: w_id_rs_addr_5 / w_id_rt_addr_5  in  5 each  decode-stage source register addresses.
REQ-006: w_id_uses_rs / w_id_uses_rt  in  1 each  decode-stage instruction reads rs / rt.
REQ-007: w_id_md_op  in  1  decode-stage instruction is MULT, MULTU, DIV or DIVU.
REQ-008: w_id_md_div  in  1  qualifies w_id_md_op: 1 = divide, 0 = multiply.
REQ-009: w_id_hilo_read  in  1  decode-stage instruction is MFHI or MFLO.
REQ-010: w_ex_mem_read  in  1  execute-stage instruction is a load (LW, LB, LBU).
REQ-011: w_ex_rd_addr_5  in  5  execute-stage destination register.
REQ-012: w_redirect  in  1  taken branch or jump resolved in execute this cycle.
REQ-013: w_stall_pc  out  1  hold the PC.
REQ-014: w_stall_id  out  1  hold the IF/ID register.
REQ-015: w_bubble_ex  out  1  load a NOP into ID/EX instead of the decoded instruction.
REQ-016: w_flush_id  out  1  replace IF/ID contents with a NOP.
REQ-017: w_md_start  out  1  one-cycle start pulse to the mult/div unit.
REQ-018: w_md_busy  out  1  mult/div unit is occupied.
REQ-019: w_md_done  out  1  one-cycle pulse: HI/LO are written at this clock edge.
REQ-020: All outputs SHALL be driven combinationally from registered state and current inputs.

Function
REQ-021: The state machine SHALL have two states: RUN and MD_BUSY. It SHALL use a 5-bit down-counter md_cnt.
REQ-022: Load-use hazard: luh = w_ex_mem_read & (w_ex_rd_addr_5 != 0) & w_id_valid & ((w_id_uses_rs & rs == rd) | (w_id_uses_rt & rt == rd)).
REQ-023: Mult/div hazard: mdh = w_id_valid & (state == MD_BUSY) & (md_cnt != 0) & (w_id_md_op | w_id_hilo_read).
REQ-024: Stall: when (luh | mdh) & !w_redirect, the block SHALL assert w_stall_pc = w_stall_id = w_bubble_ex = 1 and w_flush_id = 0.
REQ-025: Redirect: when w_redirect = 1, the block SHALL assert w_flush_id = 1 and w_bubble_ex = 1, and force w_stall_pc = w_stall_id = 0. Redirect overrides every stall.
REQ-026: w_md_start SHALL be 1 only when all of the following hold: state == RUN, w_id_valid, w_id_md_op, !luh, and !w_redirect.
REQ-027: On w_md_start, the block SHALL go to MD_BUSY and load md_cnt = 3 for a multiply (4 busy cycles) or md_cnt = 31 for a divide (32 busy cycles).
REQ-028: In MD_BUSY, md_cnt SHALL decrement by 1 each cycle. When md_cnt == 0, the block SHALL assert w_md_done and return to RUN on the next edge.
REQ-029: w_md_busy SHALL equal (state == MD_BUSY), including the w_md_done cycle.
REQ-030: In the w_md_done cycle, mdh = 0, so MFHI/MFLO or a new mult/div in decode proceeds without a stall. A new w_md_start can occur only in the following RUN cycle.
REQ-031: A redirect during MD_BUSY SHALL NOT abort the counter, because the mult/div already issued is on the correct path.
REQ-032: Non-mult/div, non-HI/LO instructions SHALL flow during MD_BUSY; only luh can stall them.
REQ-033: Register 0 SHALL never create a load-use hazard.
REQ-034: When w_id_valid = 0, the block SHALL create no hazard and no w_md_start.

Reset
REQ-035: On w_reset_n low, asynchronously and at any point, including mid-count, the block SHALL set state = RUN and md_cnt = 0.
REQ-036: While w_reset_n is low, every output SHALL be 0 (all outputs derive from the cleared state and from inputs gated by RUN).
REQ-037: After reset release, the block SHALL accept w_md_start on the first clock edge.

Verification
REQ-038: Load-use: EX = LW to r5, ID = ADD reading rs = r5 -> stall_pc = stall_id = bubble_ex = 1 for exactly 1 cycle; no stall for the same sequence with r0.
REQ-039: MULT then MFHI back-to-back -> md_start for 1 cycle, busy for 4 cycles, MFHI stalled 3 cycles, md_done on the 4th cycle with the stall released.
REQ-040: DIV then DIV -> second DIV stalled 31 cycles, second md_start on the cycle after md_done, md_cnt reloaded to 31.
REQ-041: Redirect during a load-use hazard -> flush_id = 1, bubble_ex = 1, stall_pc = 0, no md_start; redirect during MD_BUSY -> the counter continues unchanged.
REQ-042: w_reset_n pulsed low at md_cnt = 17 of a DIV -> busy = 0 and state = RUN immediately; the next MULT gives md_start on the first edge after release.
REQ-043: ADD in decode during MD_BUSY with no load-use hazard -> zero stall cycles.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Decode/execute hazard signals exchanged between the pipeline and hazard_ctrl.
// The master drives the decode/execute fields; the slave returns stall, flush and mult/div status.
interface hazard_ctrl_if;
    logic       w_id_valid;
    logic [4:0] w_id_rs_addr_5;
    logic [4:0] w_id_rt_addr_5;
    logic       w_id_uses_rs;
    logic       w_id_uses_rt;
    logic       w_id_md_op;
    logic       w_id_md_div;
    logic       w_id_hilo_read;
    logic       w_ex_mem_read;
    logic [4:0] w_ex_rd_addr_5;
    logic       w_redirect;

    logic       w_stall_pc;
    logic       w_stall_id;
    logic       w_bubble_ex;
    logic       w_flush_id;
    logic       w_md_start;
    logic       w_md_busy;
    logic       w_md_done;

    modport master (
        output w_id_valid, w_id_rs_addr_5, w_id_rt_addr_5, w_id_uses_rs, w_id_uses_rt,
               w_id_md_op, w_id_md_div, w_id_hilo_read, w_ex_mem_read, w_ex_rd_addr_5,
               w_redirect,
        input  w_stall_pc, w_stall_id, w_bubble_ex, w_flush_id, w_md_start, w_md_busy,
               w_md_done
    );

    modport slave (
        input  w_id_valid, w_id_rs_addr_5, w_id_rt_addr_5, w_id_uses_rs, w_id_uses_rt,
               w_id_md_op, w_id_md_div, w_id_hilo_read, w_ex_mem_read, w_ex_rd_addr_5,
               w_redirect,
        output w_stall_pc, w_stall_id, w_bubble_ex, w_flush_id, w_md_start, w_md_busy,
               w_md_done
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch redirect flushes and
// sequencing of the multi-cycle mult/div unit (4 cycles multiply, 32 cycles divide).
module hazard_ctrl (
    input  logic          w_clock,
    input  logic          w_reset_n,
    hazard_ctrl_if.slave  hz
);
    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    localparam logic [4:0] MUL_CNT = 5'd3;
    localparam logic [4:0] DIV_CNT = 5'd31;

    state_t     r_state;
    state_t     w_state_next;
    logic [4:0] r_md_cnt;
    logic [4:0] w_md_cnt_next;

    logic w_luh;
    logic w_mdh;
    logic w_busy;
    logic w_cnt_zero;
    logic w_start;

    assign w_busy     = (r_state == MD_BUSY);
    assign w_cnt_zero = (r_md_cnt == 5'd0);

    assign w_luh = hz.w_ex_mem_read & (hz.w_ex_rd_addr_5 != 5'd0) & hz.w_id_valid &
                   ((hz.w_id_uses_rs & (hz.w_id_rs_addr_5 == hz.w_ex_rd_addr_5)) |
                    (hz.w_id_uses_rt & (hz.w_id_rt_addr_5 == hz.w_ex_rd_addr_5)));

    // The final busy cycle (count zero) lets HI/LO readers and new mult/div ops through.
    assign w_mdh = hz.w_id_valid & w_busy & ~w_cnt_zero & (hz.w_id_md_op | hz.w_id_hilo_read);

    assign w_start = (r_state == RUN) & hz.w_id_valid & hz.w_id_md_op & ~w_luh & ~hz.w_redirect;

    always_ff @(posedge w_clock or negedge w_reset_n) begin
        if (!w_reset_n) begin
            r_state  <= RUN;
            r_md_cnt <= 5'd0;
        end else begin
            r_state  <= w_state_next;
            r_md_cnt <= w_md_cnt_next;
        end
    end

    // Redirects never touch the counter: the issued mult/div is on the correct path.
    always_comb begin
        w_state_next  = r_state;
        w_md_cnt_next = r_md_cnt;
        case (r_state)
            RUN: begin
                if (w_start) begin
                    w_state_next  = MD_BUSY;
                    w_md_cnt_next = hz.w_id_md_div ? DIV_CNT : MUL_CNT;
                end
            end
            MD_BUSY: begin
                if (w_cnt_zero) begin
                    w_state_next = RUN;
                end else begin
                    w_md_cnt_next = r_md_cnt - 5'd1;
                end
            end
            default: begin
                w_state_next  = RUN;
                w_md_cnt_next = 5'd0;
            end
        endcase
    end

    // Outputs are held low while reset is asserted, even if the inputs describe a hazard.
    always_comb begin
        hz.w_stall_pc  = 1'b0;
        hz.w_stall_id  = 1'b0;
        hz.w_bubble_ex = 1'b0;
        hz.w_flush_id  = 1'b0;
        hz.w_md_start  = 1'b0;
        hz.w_md_busy   = 1'b0;
        hz.w_md_done   = 1'b0;
        if (w_reset_n) begin
            if (hz.w_redirect) begin
                hz.w_flush_id  = 1'b1;
                hz.w_bubble_ex = 1'b1;
            end else if (w_luh | w_mdh) begin
                hz.w_stall_pc  = 1'b1;
                hz.w_stall_id  = 1'b1;
                hz.w_bubble_ex = 1'b1;
            end
            hz.w_md_start = w_start;
            hz.w_md_busy  = w_busy;
            hz.w_md_done  = w_busy & w_cnt_zero;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_hazard_ctrl;
    logic w_clock;
    logic w_reset_n;

    hazard_ctrl_if bus ();

    hazard_ctrl dut (
        .w_clock   (w_clock),
        .w_reset_n (w_reset_n),
        .hz        (bus.slave)
    );

    initial w_clock = 1'b0;
    always #5 w_clock = ~w_clock;

    // Expected vector: {stall_pc, stall_id, bubble_ex, flush_id, md_start, md_busy, md_done}
    localparam logic [6:0] E_IDLE  = 7'b0000000;
    localparam logic [6:0] E_STALL = 7'b1110000;
    localparam logic [6:0] E_REDIR = 7'b0011000;
    localparam logic [6:0] E_START = 7'b0000100;
    localparam logic [6:0] E_BUSY  = 7'b0000010;
    localparam logic [6:0] E_BSTL  = 7'b1110010;
    localparam logic [6:0] E_BRED  = 7'b0011010;
    localparam logic [6:0] E_DONE  = 7'b0000011;

    string      name_q[$];
    logic [6:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;

    always @(negedge w_clock) begin
        if (exp_q.size() > 0) begin
            string      nm;
            logic [6:0] e;
            logic [6:0] act;
            nm  = name_q.pop_front();
            e   = exp_q.pop_front();
            act = {bus.w_stall_pc, bus.w_stall_id, bus.w_bubble_ex, bus.w_flush_id,
                   bus.w_md_start, bus.w_md_busy, bus.w_md_done};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got=%b expected=%b", nm, act, e);
            end else begin
                $display("ok   %s: outputs=%b", nm, act);
            end
        end
    end

    task automatic step(input string nm, input logic [6:0] e);
        name_q.push_back(nm);
        exp_q.push_back(e);
        @(posedge w_clock);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic mdop,
                          input logic div, input logic hilo);
        bus.w_id_valid     = v;
        bus.w_id_rs_addr_5 = rs;
        bus.w_id_rt_addr_5 = rt;
        bus.w_id_uses_rs   = urs;
        bus.w_id_uses_rt   = urt;
        bus.w_id_md_op     = mdop;
        bus.w_id_md_div    = div;
        bus.w_id_hilo_read = hilo;
    endtask

    task automatic set_ex(input logic mr, input logic [4:0] rd, input logic redir);
        bus.w_ex_mem_read  = mr;
        bus.w_ex_rd_addr_5 = rd;
        bus.w_redirect     = redir;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_ex(1'b0, 5'd0, 1'b0);
    endtask

    task automatic add_r3_r4();
        set_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        set_ex(1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        w_reset_n = 1'b0;
        idle();
        @(posedge w_clock);
        #1;

        // Outputs held low in reset even with a load-use pattern and a mult/div in decode
        set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        set_ex(1'b1, 5'd5, 1'b0);
        step("reset_hold_a", E_IDLE);
        step("reset_hold_b", E_IDLE);
        w_reset_n = 1'b1;
        idle();
        step("after_reset_idle", E_IDLE);

        // Load-use on rs, exactly one stall cycle
        set_id(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        set_ex(1'b1, 5'd5, 1'b0);
        step("luh_rs_r5", E_STALL);
        set_ex(1'b0, 5'd0, 1'b0);
        step("luh_released", E_IDLE);

        set_id(1'b1, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        set_ex(1'b1, 5'd0, 1'b0);
        step("luh_r0_none", E_IDLE);

        set_id(1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        set_ex(1'b1, 5'd7, 1'b0);
        step("luh_rt_r7", E_STALL);
        set_id(1'b1, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("luh_rt_unused", E_IDLE);
        set_id(1'b0, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("luh_id_invalid", E_IDLE);
        set_id(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        set_ex(1'b0, 5'd7, 1'b0);
        step("no_load_no_luh", E_IDLE);

        // Redirect beats a load-use stall and blocks md_start
        set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        set_ex(1'b1, 5'd5, 1'b1);
        step("redir_over_luh", E_REDIR);
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        set_ex(1'b0, 5'd0, 1'b1);
        step("redir_blocks_start", E_REDIR);
        // A load-use hazard on the mult itself also blocks md_start
        set_ex(1'b1, 5'd2, 1'b0);
        step("luh_blocks_start", E_STALL);

        // MULT then MFHI back to back
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        set_ex(1'b0, 5'd0, 1'b0);
        step("mult_start", E_START);
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step("mfhi_stall", E_BSTL);
        step("mult_done_mfhi_go", E_DONE);
        idle();
        step("mult_back_run", E_IDLE);

        // ADD flows through MD_BUSY with no stalls
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("mult2_start", E_START);
        add_r3_r4();
        for (int i = 0; i < 3; i++) step("add_in_busy", E_BUSY);
        step("add_in_done", E_DONE);
        // Load-use still stalls inside MD_BUSY
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("mult3_start", E_START);
        set_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        set_ex(1'b1, 5'd9, 1'b0);
        step("luh_in_busy", E_BSTL);
        add_r3_r4();
        step("add_after_luh", E_BUSY);
        step("add_busy_cnt1", E_BUSY);
        step("mult3_done", E_DONE);

        // DIV then DIV, with a redirect in the middle that must not disturb the count
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        set_ex(1'b0, 5'd0, 1'b0);
        step("div1_start", E_START);
        for (int i = 0; i < 31; i++) begin
            bus.w_redirect = (i == 10);
            step((i == 10) ? "div2_redirect_busy" : "div2_stall", (i == 10) ? E_BRED : E_BSTL);
        end
        bus.w_redirect = 1'b0;
        step("div1_done_no_stall", E_DONE);
        step("div2_start", E_START);
        idle();
        for (int i = 0; i < 31; i++) step("div2_busy", E_BUSY);
        step("div2_done", E_DONE);
        step("div2_back_run", E_IDLE);

        // Reset in the middle of a divide at count 17
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step("div3_start", E_START);
        idle();
        for (int i = 0; i < 14; i++) step("div3_busy", E_BUSY);
        w_reset_n = 1'b0;
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("reset_at_cnt17", E_IDLE);
        w_reset_n = 1'b1;
        step("mult_first_edge", E_START);
        idle();
        for (int i = 0; i < 3; i++) step("mult4_busy", E_BUSY);
        step("mult4_done", E_DONE);
        step("final_idle", E_IDLE);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge w_clock);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL monitor_drain: got=%0d pending expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
